motor_ramp_ctrl: RTL
====================

# motor_ramp_ctrl

- Sequences the two drive motors of the car from a 2-bit motion command.
- Produces per-side 10-bit PWM duty values and H-bridge direction pins.
  - Duty changes are slew-limited.
  - Direction reversals are sequenced as brake, then dead time, then re-drive.
- Sits between the car's decision logic and the per-side PWM generators: duties go to the duty inputs of the 25 kHz PWM instances, direction pins go straight to the board.

## Interface
- TICK_DIV, 100000: clk cycles per ramp tick (1 ms at 100 MHz); must be ≥2.
- STEP, 16: duty change per tick; 1..1023.
- FWD_DUTY, 768: target duty for forward mode.
- TURN_DUTY, 512: target duty of both sides in pivot-turn modes.
- DEAD_TICKS, 4: ticks with direction pins at 00 between brake and reverse drive; ≥1.
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- mode  in  2  00 stop, 01 forward, 10 pivot left, 11 pivot right; sampled every cycle
- estop  in  1  synchronous emergency stop, active-high, level
- left_duty  out  10  duty to left PWM generator
- right_duty  out  10  duty to right PWM generator
- l_IN  out  2  left bridge: 10 forward, 01 reverse, 00 coast
- r_IN  out  2  right bridge, same encoding
- busy  out  1  high while either side is ramping, braking or in dead time

## Operation
- Target per mode, as side: direction/duty:
  - 00: both sides duty 0.
  - 01: both sides fwd/FWD_DUTY.
  - 10: left rev/TURN_DUTY, right fwd/TURN_DUTY.
  - 11: left fwd/TURN_DUTY, right rev/TURN_DUTY.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; tick = 1 for one cycle when the counter equals TICK_DIV-1.
  - Not restarted by mode changes.
  - Cleared only by reset.
- Ramp step, applied on tick only, computed in 11 bits:
  - If duty < target: duty = min(duty+STEP, target).
  - If duty > target: duty = max(duty-STEP, target).
  - Never overshoots, never wraps.
- Each side has an identical independent FSM with states IDLE, RUN, BRAKE, DEAD and registers dir, duty, deadcnt.
  - IDLE (duty 0, IN 00): nonzero target → RUN, dir := target dir.
  - RUN (IN = dir): ramp toward target.
    - Target nonzero with opposite dir → BRAKE.
    - Target 0 and duty 0 → IDLE.
  - BRAKE (IN = dir): ramp toward 0 on ticks.
    - Target back to the same dir and nonzero → RUN; ramp resumes from the current duty.
    - duty == 0 → DEAD, deadcnt := 0.
  - DEAD (IN 00, duty 0): deadcnt increments on each tick; → IDLE on the tick where deadcnt reaches DEAD_TICKS-1. IDLE then re-enters RUN with the new dir.
- estop, highest priority, evaluated every cycle:
  - Next cycle: both duties 0, IN 00, both FSMs in DEAD, deadcnt := 0.
  - Held in that condition while estop = 1.
  - On release, the normal DEAD exit runs, so DEAD_TICKS full ticks pass before any drive.
- busy = OR over sides of (state ∈ {BRAKE, DEAD}) or (duty ≠ current target). busy is registered.
- Reset values: duties 0, IN 00, busy 0, both FSMs IDLE, dir forward, tick counter 0, deadcnt 0.

## Timing
- All outputs are registered; there is no combinational path from mode or estop to any output.
- Mode change to IN update (IDLE→RUN): 1 cycle.
- First duty step after entering RUN: on the next tick, i.e. 1..TICK_DIV cycles later.
- Full ramp 0→FWD_DUTY with defaults: 48 ticks.
- Reversal from duty D: ceil(D/STEP) ticks of braking, then DEAD_TICKS ticks at IN 00, then ramp-up.
- Within a tick there is at most one duty change per side. DEAD→IDLE→RUN costs one extra cycle, not one extra tick.
- estop asserted: duties 0 and IN 00 on the following clock edge, regardless of tick phase.
- Reset asserted mid-ramp: outputs go to reset values asynchronously. After release, operation restarts from IDLE with the tick counter at 0.
- Mode toggling faster than ticks: only the mode present in a given cycle matters. Nothing is queued.

## Test plan
1. Reset/hold: reset asserted with mode 01.
   - Required: duties 0, IN 00, busy 0.
   - After release, with TICK_DIV = 4: IN = 10 one cycle later; duty 16 at the first tick.
2. Forward ramp, TICK_DIV = 4, STEP = 16: mode 00→01.
   - Required: both duties +16 per tick, reaching 768 after 48 ticks.
   - busy falls the cycle after 768 is reached.
3. Reversal: from steady forward 768, mode → 10.
   - Left: 768→0 over 48 ticks, then IN 00 for 4 ticks, then IN 01, then 0→512.
   - Right: stays IN 10, 768→512 over 16 ticks.
4. Brake abort: mode 10 applied, then 01 restored while left duty is 400 in BRAKE.
   - Required: left returns to RUN at IN 10 and ramps 400→768 without reaching 0.
5. estop mid-ramp at duty 320: estop = 1 for 10 cycles.
   - Next cycle: duties 0, IN 00.
   - After release with mode 01: exactly 4 ticks at IN 00 before IN 10.
6. Saturation: STEP = 100, mode 01 from 0.
   - Up: 700 then 768, never 800.
   - Then mode 00 from 768: down 68 then 0 with no wrap; IN 00 once 0 is reached.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// Two-sided drive sequencer: slew-limited 10-bit duties per side and
// brake / dead-time / re-drive sequencing of the H-bridge direction pins.

module motor_ramp_side #(
    parameter int STEP       = 16,
    parameter int DEAD_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       estop,
    input  logic       tgt_fwd,
    input  logic [9:0] tgt_duty,
    output logic [9:0] duty,
    output logic [1:0] bridge,
    output logic       busy_term
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BRAKE = 2'd2, DEAD = 2'd3} state_t;

    localparam int             DCW       = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_TICKS - 1);
    localparam logic [10:0]    STEP11    = 11'(STEP);

    state_t         state_r, state_s;
    logic           dir_r, dir_s;
    logic [9:0]     duty_r, duty_s;
    logic [DCW-1:0] dcnt_r, dcnt_s;
    logic [1:0]     bridge_r, bridge_s;

    // One slew step toward tgt in 11 bits so neither direction can wrap or overshoot.
    function automatic logic [9:0] ramp_to(input logic [9:0] cur, input logic [9:0] tgt);
        logic [10:0] cur_s;
        logic [10:0] tgt_s;
        cur_s = {1'b0, cur};
        tgt_s = {1'b0, tgt};
        if (cur_s < tgt_s) begin
            ramp_to = ((cur_s + STEP11) >= tgt_s) ? tgt : 10'(cur_s + STEP11);
        end else if (cur_s > tgt_s) begin
            ramp_to = ((cur_s - tgt_s) <= STEP11) ? tgt : 10'(cur_s - STEP11);
        end else begin
            ramp_to = cur;
        end
    endfunction

    // Next-state, duty and bridge decode; estop overrides every state.
    always_comb begin
        state_s = state_r;
        dir_s   = dir_r;
        duty_s  = duty_r;
        dcnt_s  = dcnt_r;
        if (estop) begin
            state_s = DEAD;
            duty_s  = 10'd0;
            dcnt_s  = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    duty_s = 10'd0;
                    if (tgt_duty != 10'd0) begin
                        state_s = RUN;
                        dir_s   = tgt_fwd;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if ((tgt_duty != 10'd0) && (tgt_fwd != dir_r)) begin
                        state_s = BRAKE;
                    end else if ((tgt_duty == 10'd0) && (duty_r == 10'd0)) begin
                        state_s = IDLE;
                    end else if (tick) begin
                        duty_s = ramp_to(duty_r, tgt_duty);
                    end else begin
                        duty_s = duty_r;
                    end
                end
                BRAKE: begin
                    if ((tgt_duty != 10'd0) && (tgt_fwd == dir_r)) begin
                        state_s = RUN;
                    end else if (duty_r == 10'd0) begin
                        state_s = DEAD;
                        dcnt_s  = '0;
                    end else if (tick) begin
                        duty_s = ramp_to(duty_r, 10'd0);
                    end else begin
                        duty_s = duty_r;
                    end
                end
                DEAD: begin
                    duty_s = 10'd0;
                    if (tick) begin
                        if (dcnt_r == DEAD_LAST) begin
                            state_s = IDLE;
                            dcnt_s  = '0;
                        end else begin
                            dcnt_s = dcnt_r + 1'b1;
                        end
                    end else begin
                        dcnt_s = dcnt_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    duty_s  = 10'd0;
                end
            endcase
        end
        case (state_s)
            RUN, BRAKE: bridge_s = dir_s ? 2'b10 : 2'b01;
            default:    bridge_s = 2'b00;
        endcase
    end

    // Side state, duty and bridge registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            dir_r    <= 1'b1;
            duty_r   <= 10'd0;
            dcnt_r   <= '0;
            bridge_r <= 2'b00;
        end else begin
            state_r  <= state_s;
            dir_r    <= dir_s;
            duty_r   <= duty_s;
            dcnt_r   <= dcnt_s;
            bridge_r <= bridge_s;
        end
    end

    assign duty      = duty_r;
    assign bridge    = bridge_r;
    assign busy_term = (state_r == BRAKE) || (state_r == DEAD) || (duty_r != tgt_duty);
endmodule

module motor_ramp_ctrl #(
    parameter int TICK_DIV   = 100000,
    parameter int STEP       = 16,
    parameter int FWD_DUTY   = 768,
    parameter int TURN_DUTY  = 512,
    parameter int DEAD_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       estop,
    output logic [9:0] left_duty,
    output logic [9:0] right_duty,
    output logic [1:0] l_IN,
    output logic [1:0] r_IN,
    output logic       busy
);
    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]    FWD10     = 10'(FWD_DUTY);
    localparam logic [9:0]    TURN10    = 10'(TURN_DUTY);

    logic [CW-1:0] tcnt_r;
    logic          tick_s;
    logic          l_fwd_s, r_fwd_s;
    logic [9:0]    l_tgt_s, r_tgt_s;
    logic          l_busy_s, r_busy_s;
    logic          busy_r;

    assign tick_s = (tcnt_r == TICK_LAST);

    // Free-running ramp tick divider; mode changes never restart it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_r <= '0;
        end else if (tick_s) begin
            tcnt_r <= '0;
        end else begin
            tcnt_r <= tcnt_r + 1'b1;
        end
    end

    // Mode to per-side direction and target duty.
    always_comb begin
        l_fwd_s = 1'b1;
        r_fwd_s = 1'b1;
        l_tgt_s = 10'd0;
        r_tgt_s = 10'd0;
        case (mode)
            2'b01: begin
                l_tgt_s = FWD10;
                r_tgt_s = FWD10;
            end
            2'b10: begin
                l_fwd_s = 1'b0;
                l_tgt_s = TURN10;
                r_tgt_s = TURN10;
            end
            2'b11: begin
                r_fwd_s = 1'b0;
                l_tgt_s = TURN10;
                r_tgt_s = TURN10;
            end
            default: begin
                l_tgt_s = 10'd0;
                r_tgt_s = 10'd0;
            end
        endcase
    end

    motor_ramp_side #(.STEP(STEP), .DEAD_TICKS(DEAD_TICKS)) u_left (
        .clk(clk), .reset(reset), .tick(tick_s), .estop(estop),
        .tgt_fwd(l_fwd_s), .tgt_duty(l_tgt_s),
        .duty(left_duty), .bridge(l_IN), .busy_term(l_busy_s)
    );

    motor_ramp_side #(.STEP(STEP), .DEAD_TICKS(DEAD_TICKS)) u_right (
        .clk(clk), .reset(reset), .tick(tick_s), .estop(estop),
        .tgt_fwd(r_fwd_s), .tgt_duty(r_tgt_s),
        .duty(right_duty), .bridge(r_IN), .busy_term(r_busy_s)
    );

    // Registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= l_busy_s | r_busy_s;
        end
    end

    assign busy = busy_r;
endmodule
